// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: state encoding and default timing constants shared by the pipeline sequencer
package pipe_ctrl_pkg;
  localparam logic [2:0] ST_INIT   = 3'd0;
  localparam logic [2:0] ST_RUN    = 3'd1;
  localparam logic [2:0] ST_LSTALL = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;
  localparam logic [2:0] ST_STEP   = 3'd5;
  localparam int unsigned RST_HOLD_DEF = 5;
  localparam int unsigned DRAIN_DEF    = 4;
  localparam int unsigned CNT_W_DEF    = 16;
endpackage

// File: rtl/pipe_ctrl_cnt.sv
// pipe_ctrl_cnt: 3-bit down-counter (load has priority, dec=0 freezes, stops at zero); ports clk, load, load_val, dec, cnt, zero
module pipe_ctrl_cnt (
  input  logic       clk,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       dec,
  output logic [2:0] cnt,
  output logic       zero
);
  always_ff @(posedge clk)
    if (load) cnt <= load_val;
    else if (dec && !zero) cnt <= cnt - 3'd1;
  assign zero = cnt == 3'd0;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage sequencer turning hazards/branches/debug halt into Mealy stall/flush/bubble controls; ports clk, rst, hz_load, br_taken, halt_req, step_req, wb_valid -> stall_fe, stall_re, bubble_ex, flush_fe, flush_re, run, halted, state, stall_cnt, ret_cnt (counters live only with PIPE_PERF_CNT_EN)
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned RST_HOLD   = RST_HOLD_DEF,
  parameter int unsigned LOAD_STALL = 1,
  parameter int unsigned DRAIN      = DRAIN_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hz_load,
  input  logic             br_taken,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             wb_valid,
  output logic             stall_fe,
  output logic             stall_re,
  output logic             bubble_ex,
  output logic             flush_fe,
  output logic             flush_re,
  output logic             run,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] ret_cnt
);
  logic [2:0] nxt, cnt, ld_val;
  logic ld, dec, zero;
  pipe_ctrl_cnt u_cnt (
    .clk(clk),
    .load(ld),
    .load_val(ld_val),
    .dec(dec),
    .cnt(cnt),
    .zero(zero)
  );
  always_comb begin
    stall_fe = 1'b0;
    stall_re = 1'b0;
    bubble_ex = 1'b0;
    flush_fe = 1'b0;
    flush_re = 1'b0;
    nxt = state;
    ld = 1'b0;
    ld_val = 3'(DRAIN - 1);
    dec = 1'b0;
    case (state)
      ST_INIT: begin
        stall_fe = 1'b1;
        bubble_ex = 1'b1;
        flush_fe = 1'b1;
        flush_re = 1'b1;
        dec = 1'b1;
        nxt = zero ? ST_RUN : ST_INIT;
      end
      ST_RUN:
        if (br_taken) begin
          flush_fe = 1'b1;
          flush_re = 1'b1;
        end else if (hz_load) begin
          stall_fe = 1'b1;
          stall_re = 1'b1;
          bubble_ex = 1'b1;
          if (LOAD_STALL > 1) begin
            nxt = ST_LSTALL;
            ld = 1'b1;
            ld_val = 3'(LOAD_STALL - 2);
          end
        end else if (halt_req) begin
          nxt = ST_DRAIN;
          ld = 1'b1;
        end
      ST_LSTALL:
        if (br_taken) begin
          flush_fe = 1'b1;
          flush_re = 1'b1;
          nxt = ST_RUN;
        end else begin
          stall_fe = 1'b1;
          stall_re = 1'b1;
          bubble_ex = 1'b1;
          dec = 1'b1;
          nxt = zero ? ST_RUN : ST_LSTALL;
        end
      ST_DRAIN: begin
        stall_fe = 1'b1;
        flush_fe = 1'b1;
        flush_re = br_taken;
        stall_re = hz_load & ~br_taken;
        bubble_ex = hz_load & ~br_taken;
        dec = ~(hz_load & ~br_taken);
        nxt = dec && zero ? ST_HALT : ST_DRAIN;
      end
      ST_HALT: begin
        stall_fe = 1'b1;
        flush_fe = 1'b1;
        nxt = !halt_req ? ST_RUN : step_req ? ST_STEP : ST_HALT;
      end
      ST_STEP: begin
        nxt = ST_DRAIN;
        ld = 1'b1;
      end
      default: nxt = ST_INIT;
    endcase
    if (rst) begin
      nxt = ST_INIT;
      ld = 1'b1;
      ld_val = 3'(RST_HOLD - 1);
    end
  end
  always_ff @(posedge clk) state <= nxt;
  assign run = state == ST_RUN;
  assign halted = state == ST_HALT;
`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk)
    if (rst) begin
      stall_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      if (bubble_ex && state != ST_INIT && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (wb_valid && !(&ret_cnt)) ret_cnt <= ret_cnt + 1'b1;
    end
`else
  logic unused_wb;
  assign unused_wb = wb_valid;
  assign stall_cnt = '0;
  assign ret_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: table-driven scoreboard bench for pipe_ctrl with LOAD_STALL=1 and LOAD_STALL=3 instances
module tb_pipe_ctrl;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  typedef struct packed {
    logic [4:0] in;
    logic [2:0] st;
    logic [4:0] ctl;
  } vec_t;
  logic clk, rst, hz_load, br_taken, halt_req, step_req, wb_valid;
  logic a_sfe, a_sre, a_bex, a_ffe, a_fre, a_run, a_hlt;
  logic b_sfe, b_sre, b_bex, b_ffe, b_fre, b_run, b_hlt;
  logic [2:0] a_st, b_st;
  logic [15:0] a_scnt, a_rcnt, b_scnt, b_rcnt;
  vec_t tv[$];
  vec_t sb[$];
  vec_t e;
  int n_chk = 0;
  int n_fail = 0;
  int n;
  pipe_ctrl #(.LOAD_STALL(1)) u1 (
    .clk(clk), .rst(rst), .hz_load(hz_load), .br_taken(br_taken), .halt_req(halt_req),
    .step_req(step_req), .wb_valid(wb_valid), .stall_fe(a_sfe), .stall_re(a_sre),
    .bubble_ex(a_bex), .flush_fe(a_ffe), .flush_re(a_fre), .run(a_run), .halted(a_hlt),
    .state(a_st), .stall_cnt(a_scnt), .ret_cnt(a_rcnt)
  );
  pipe_ctrl #(.LOAD_STALL(3)) u3 (
    .clk(clk), .rst(rst), .hz_load(hz_load), .br_taken(br_taken), .halt_req(halt_req),
    .step_req(step_req), .wb_valid(wb_valid), .stall_fe(b_sfe), .stall_re(b_sre),
    .bubble_ex(b_bex), .flush_fe(b_ffe), .flush_re(b_fre), .run(b_run), .halted(b_hlt),
    .state(b_st), .stall_cnt(b_scnt), .ret_cnt(b_rcnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic add(input logic [4:0] in, input logic [2:0] st, input logic [4:0] ctl);
    tv.push_back('{in: in, st: st, ctl: ctl});
  endtask
  task automatic drive(input logic [4:0] in);
    {hz_load, br_taken, halt_req, step_req, wb_valid} = in;
  endtask
  initial begin
    add(5'b00000, 3'd0, 5'b10111);
    add(5'b00000, 3'd0, 5'b10111);
    add(5'b10000, 3'd0, 5'b10111);
    add(5'b00000, 3'd0, 5'b10111);
    add(5'b00000, 3'd0, 5'b10111);
    add(5'b00000, 3'd1, 5'b00000);
    add(5'b10000, 3'd1, 5'b11100);
    add(5'b00000, 3'd1, 5'b00000);
    add(5'b11000, 3'd1, 5'b00011);
    add(5'b00000, 3'd1, 5'b00000);
    add(5'b01100, 3'd1, 5'b00011);
    add(5'b00100, 3'd1, 5'b00000);
    add(5'b00100, 3'd3, 5'b10010);
    add(5'b10100, 3'd3, 5'b11110);
    add(5'b01100, 3'd3, 5'b10011);
    add(5'b00100, 3'd3, 5'b10010);
    add(5'b00100, 3'd3, 5'b10010);
    add(5'b00100, 3'd4, 5'b10010);
    add(5'b00110, 3'd4, 5'b10010);
    add(5'b00111, 3'd5, 5'b00000);
    add(5'b00110, 3'd3, 5'b10010);
    add(5'b00100, 3'd3, 5'b10010);
    add(5'b00100, 3'd3, 5'b10010);
    add(5'b00100, 3'd3, 5'b10010);
    add(5'b00100, 3'd4, 5'b10010);
    add(5'b00010, 3'd4, 5'b10010);
    add(5'b00000, 3'd1, 5'b00000);
    rst = 1'b1;
    drive(5'b0);
    for (int i = 0; i < 3; i++) tick();
    chk("rst_state", a_st, 3'd0);
    chk("rst_ctl", {a_sfe, a_sre, a_bex, a_ffe, a_fre}, 5'b10111);
    chk("rst_run_halted", {a_run, a_hlt}, 2'b00);
    chk("rst_stall_cnt", a_scnt, 0);
    chk("rst_ret_cnt", a_rcnt, 0);
    rst = 1'b0;
    foreach (tv[i]) begin
      drive(tv[i].in);
      sb.push_back(tv[i]);
      #2;
      e = sb.pop_front();
      chk($sformatf("v%0d_state", i), a_st, e.st);
      chk($sformatf("v%0d_ctl", i), {a_sfe, a_sre, a_bex, a_ffe, a_fre}, e.ctl);
      chk($sformatf("v%0d_run", i), a_run, e.st == 3'd1);
      chk($sformatf("v%0d_halted", i), a_hlt, e.st == 3'd4);
      tick();
    end
    drive(5'b0);
    chk("ls1_stall_cnt", a_scnt, PERF ? 2 : 0);
    chk("ls1_ret_cnt", a_rcnt, PERF ? 1 : 0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0;
    n = 0;
    for (int c = 0; c < 12 && !b_run; c++) begin
      n += int'(b_ffe);
      tick();
    end
    chk("hold_flush_cycles", n, 5);
    chk("hold_then_run", {b_run, b_st}, {1'b1, 3'd1});
    hz_load = 1'b1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      #2;
      n += int'(b_bex);
      tick();
      hz_load = 1'b0;
    end
    chk("ls3_bubble_cycles", n, 3);
    chk("ls3_back_to_run", b_st, 3'd1);
    chk("ls3_stall_cnt", b_scnt, PERF ? 3 : 0);
    hz_load = 1'b1;
    tick();
    hz_load = 1'b0;
    br_taken = 1'b1;
    #2;
    chk("lstall_br_state", b_st, 3'd2);
    chk("lstall_br_ctl", {b_sfe, b_sre, b_bex, b_ffe, b_fre}, 5'b00011);
    tick();
    br_taken = 1'b0;
    #2;
    chk("lstall_br_exit", b_st, 3'd1);
    tick();
    hz_load = 1'b1;
    tick();
    hz_load = 1'b0;
    rst = 1'b1;
    #2;
    chk("mid_lstall_state", b_st, 3'd2);
    chk("mid_lstall_bubble", b_bex, 1'b1);
    tick();
    rst = 1'b0;
    #2;
    chk("mid_rst_state", b_st, 3'd0);
    chk("mid_rst_stall_cnt", b_scnt, 0);
    n = 0;
    for (int c = 0; c < 12 && !b_run; c++) begin
      n += int'(b_ffe);
      tick();
    end
    chk("rehold_flush_cycles", n, 5);
    chk("rehold_run", b_st, 3'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
